// File: rtl/alu_dispatch.sv
// In-order dispatch queue feeding two ALU reservation stations, with result-tag wakeup
// applied to queued, incoming and dispatching instructions.
module alu_dispatch #(
   parameter int unsigned OP_W     = 6,
   parameter int unsigned TAG_W    = 5,
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned RADDR_W  = 5,
   parameter int unsigned UNLOCKED = 0,
   parameter int unsigned DEPTH    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    in_op,
   input  logic [TAG_W-1:0]   in_tagx,
   input  logic [TAG_W-1:0]   in_tagy,
   input  logic [TAG_W-1:0]   in_tagw,
   input  logic [WORD_W-1:0]  in_datax,
   input  logic [WORD_W-1:0]  in_datay,
   input  logic [RADDR_W-1:0] in_addrw,
   input  logic               slot_busy0,
   input  logic               slot_busy1,
   input  logic               res_valid0,
   input  logic               res_valid1,
   input  logic [TAG_W-1:0]   res_tag0,
   input  logic [TAG_W-1:0]   res_tag1,
   input  logic [WORD_W-1:0]  res_data0,
   input  logic [WORD_W-1:0]  res_data1,
   output logic               en0,
   output logic               en1,
   output logic [OP_W-1:0]    op0,
   output logic [TAG_W-1:0]   tagx0,
   output logic [TAG_W-1:0]   tagy0,
   output logic [TAG_W-1:0]   tagw0,
   output logic [WORD_W-1:0]  datax0,
   output logic [WORD_W-1:0]  datay0,
   output logic [RADDR_W-1:0] addrw0,
   output logic [OP_W-1:0]    op1,
   output logic [TAG_W-1:0]   tagx1,
   output logic [TAG_W-1:0]   tagy1,
   output logic [TAG_W-1:0]   tagw1,
   output logic [WORD_W-1:0]  datax1,
   output logic [WORD_W-1:0]  datay1,
   output logic [RADDR_W-1:0] addrw1
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [TAG_W-1:0] UNLK = TAG_W'(UNLOCKED);

   typedef struct packed {
      logic [OP_W-1:0]    op;
      logic [TAG_W-1:0]   tagx;
      logic [TAG_W-1:0]   tagy;
      logic [TAG_W-1:0]   tagw;
      logic [WORD_W-1:0]  datax;
      logic [WORD_W-1:0]  datay;
      logic [RADDR_W-1:0] addrw;
   } entry_t;

   localparam entry_t RstEntry = '{op: '0, tagx: UNLK, tagy: UNLK, tagw: UNLK,
                                   datax: '0, datay: '0, addrw: '0};

   // Broadcast 0 takes priority when both buses carry a matching tag.
   function automatic entry_t wake(input entry_t e,
                                   input logic v0, input logic [TAG_W-1:0] t0,
                                   input logic [WORD_W-1:0] d0,
                                   input logic v1, input logic [TAG_W-1:0] t1,
                                   input logic [WORD_W-1:0] d1);
      entry_t r;
      logic   hit0, hit1;
      hit0 = v0 && (t0 != UNLK);
      hit1 = v1 && (t1 != UNLK);
      r = e;
      if (hit0 && e.tagx == t0) begin
         r.tagx  = UNLK;
         r.datax = d0;
      end else if (hit1 && e.tagx == t1) begin
         r.tagx  = UNLK;
         r.datax = d1;
      end
      if (hit0 && e.tagy == t0) begin
         r.tagy  = UNLK;
         r.datay = d0;
      end else if (hit1 && e.tagy == t1) begin
         r.tagy  = UNLK;
         r.datay = d1;
      end
      if ((hit0 && e.tagw == t0) || (hit1 && e.tagw == t1)) begin
         r.tagw = UNLK;
      end
      return r;
   endfunction

   entry_t             mem_q [DEPTH];
   entry_t             mem_w [DEPTH];
   entry_t             mem_d [DEPTH];
   entry_t             in_e, in_w, head0, head1, pl0, pl1, out0_q, out1_q;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               en0_q, en0_d, en1_q, en1_d;
   logic               free0, free1, enq, has1, has2;
   logic [1:0]         n_deq;

   assign in_e = '{op: in_op, tagx: in_tagx, tagy: in_tagy, tagw: in_tagw,
                   datax: in_datax, datay: in_datay, addrw: in_addrw};

   assign in_ready = !rst && (count_q < CNT_W'(DEPTH));

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_w[i] = wake(mem_q[i], res_valid0, res_tag0, res_data0,
                         res_valid1, res_tag1, res_data1);
      end
      in_w = wake(in_e, res_valid0, res_tag0, res_data0, res_valid1, res_tag1, res_data1);

      enq   = in_valid && in_ready && !flush;
      mem_d = mem_w;
      if (enq) begin
         mem_d[wr_ptr_q] = in_w;
      end

      // A station that was strobed last cycle has not yet reported busy.
      free0 = !slot_busy0 && !en0_q;
      free1 = !slot_busy1 && !en1_q;
      has1  = (count_q != '0);
      has2  = (count_q >= CNT_W'(2));
      head0 = mem_w[rd_ptr_q];
      head1 = mem_w[rd_ptr_q + PTR_W'(1)];

      en0_d = has1 && free0;
      en1_d = has1 && free1 && (!free0 || has2);
      pl0   = head0;
      pl1   = free0 ? head1 : head0;
      n_deq = {1'b0, en0_d} + {1'b0, en1_d};

      rd_ptr_d = rd_ptr_q + PTR_W'(n_deq);
      wr_ptr_d = wr_ptr_q + PTR_W'(enq);
      count_d  = count_q + CNT_W'(enq) - CNT_W'(n_deq);
   end

   always_ff @(posedge clk) begin
      if (rdy && !rst) begin
         mem_q <= mem_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         en0_q    <= 1'b0;
         en1_q    <= 1'b0;
         out0_q   <= RstEntry;
         out1_q   <= RstEntry;
      end else if (!rdy) begin
         en0_q <= 1'b0;
         en1_q <= 1'b0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         en0_q    <= 1'b0;
         en1_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         en0_q    <= en0_d;
         en1_q    <= en1_d;
         if (en0_d) begin
            out0_q <= pl0;
         end
         if (en1_d) begin
            out1_q <= pl1;
         end
      end
   end

   assign en0    = en0_q;
   assign en1    = en1_q;
   assign op0    = out0_q.op;
   assign tagx0  = out0_q.tagx;
   assign tagy0  = out0_q.tagy;
   assign tagw0  = out0_q.tagw;
   assign datax0 = out0_q.datax;
   assign datay0 = out0_q.datay;
   assign addrw0 = out0_q.addrw;
   assign op1    = out1_q.op;
   assign tagx1  = out1_q.tagx;
   assign tagy1  = out1_q.tagy;
   assign tagw1  = out1_q.tagw;
   assign datax1 = out1_q.datax;
   assign datay1 = out1_q.datay;
   assign addrw1 = out1_q.addrw;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: queue-level reference model checked every cycle, plus
// hand-computed literal expectations for each scenario.
module tb_alu_dispatch;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  tagx;
      logic [4:0]  tagy;
      logic [4:0]  tagw;
      logic [31:0] datax;
      logic [31:0] datay;
      logic [4:0]  addrw;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1, rdy = 1'b1, flush = 1'b0, in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_op = '0;
   logic [4:0]  in_tagx = '0, in_tagy = '0, in_tagw = '0, in_addrw = '0;
   logic [31:0] in_datax = '0, in_datay = '0;
   logic        slot_busy0 = 1'b0, slot_busy1 = 1'b0;
   logic        res_valid0 = 1'b0, res_valid1 = 1'b0;
   logic [4:0]  res_tag0 = '0, res_tag1 = '0;
   logic [31:0] res_data0 = '0, res_data1 = '0;
   logic        en0, en1;
   logic [5:0]  op0, op1;
   logic [4:0]  tagx0, tagy0, tagw0, addrw0, tagx1, tagy1, tagw1, addrw1;
   logic [31:0] datax0, datay0, datax1, datay1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_dispatch dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .in_op(in_op), .in_tagx(in_tagx), .in_tagy(in_tagy),
      .in_tagw(in_tagw), .in_datax(in_datax), .in_datay(in_datay), .in_addrw(in_addrw),
      .slot_busy0(slot_busy0), .slot_busy1(slot_busy1),
      .res_valid0(res_valid0), .res_valid1(res_valid1),
      .res_tag0(res_tag0), .res_tag1(res_tag1), .res_data0(res_data0), .res_data1(res_data1),
      .en0(en0), .en1(en1),
      .op0(op0), .tagx0(tagx0), .tagy0(tagy0), .tagw0(tagw0),
      .datax0(datax0), .datay0(datay0), .addrw0(addrw0),
      .op1(op1), .tagx1(tagx1), .tagy1(tagy1), .tagw1(tagw1),
      .datax1(datax1), .datay1(datay1), .addrw1(addrw1)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: an ordered list of pending instructions.
   ent_t mq[$];
   logic m_en0 = 1'b0, m_en1 = 1'b0;
   ent_t m_o0 = '0, m_o1 = '0;

   function automatic bit hit(input logic [4:0] tag, input logic v, input logic [4:0] t);
      return v && (t != 5'd0) && (tag == t);
   endfunction

   function automatic ent_t wk(input ent_t e);
      ent_t r = e;
      if (hit(e.tagx, res_valid0, res_tag0)) begin r.tagx = 0; r.datax = res_data0; end
      else if (hit(e.tagx, res_valid1, res_tag1)) begin r.tagx = 0; r.datax = res_data1; end
      if (hit(e.tagy, res_valid0, res_tag0)) begin r.tagy = 0; r.datay = res_data0; end
      else if (hit(e.tagy, res_valid1, res_tag1)) begin r.tagy = 0; r.datay = res_data1; end
      if (hit(e.tagw, res_valid0, res_tag0) || hit(e.tagw, res_valid1, res_tag1)) r.tagw = 0;
      return r;
   endfunction

   initial forever begin
      ent_t inw;
      bit   acc, f0, f1, n0, n1;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_en0 = 0; m_en1 = 0; m_o0 = '0; m_o1 = '0;
      end else if (!rdy) begin
         m_en0 = 0; m_en1 = 0;
      end else if (flush) begin
         mq.delete();
         m_en0 = 0; m_en1 = 0;
      end else begin
         acc = in_valid && (mq.size() < DEPTH);
         inw = wk('{in_op, in_tagx, in_tagy, in_tagw, in_datax, in_datay, in_addrw});
         foreach (mq[i]) mq[i] = wk(mq[i]);
         f0 = !slot_busy0 && !m_en0;
         f1 = !slot_busy1 && !m_en1;
         n0 = 0; n1 = 0;
         if (mq.size() >= 2 && f0 && f1) begin
            m_o0 = mq.pop_front(); m_o1 = mq.pop_front(); n0 = 1; n1 = 1;
         end else if (mq.size() >= 1 && f0) begin
            m_o0 = mq.pop_front(); n0 = 1;
         end else if (mq.size() >= 1 && f1) begin
            m_o1 = mq.pop_front(); n1 = 1;
         end
         if (acc) mq.push_back(inw);
         m_en0 = n0; m_en1 = n1;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("en", {en0, en1}, {m_en0, m_en1});
      chk("in_ready", in_ready, !rst && (mq.size() < DEPTH));
      chk("pl0", {op0, tagx0, tagy0, tagw0, datax0, datay0, addrw0}, m_o0);
      chk("pl1", {op1, tagx1, tagy1, tagw1, datax1, datay1, addrw1}, m_o1);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [5:0] op, input logic [4:0] tx, input logic [4:0] ty,
                      input logic [4:0] tw, input logic [31:0] dx, input logic [31:0] dy,
                      input logic [4:0] aw);
      in_valid = 1; in_op = op; in_tagx = tx; in_tagy = ty; in_tagw = tw;
      in_datax = dx; in_datay = dy; in_addrw = aw;
   endtask

   logic [5:0] got[$];

   initial begin
      // Reset state
      cyc(); cyc();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_en", {en0, en1}, 2'b00);
      chk("rst_pl0", {op0, tagx0, datax0, addrw0}, 0);
      rst = 0;
      cyc();

      // Single op, minimum latency
      put(5, 0, 0, 2, 7, 9, 3);
      cyc(); in_valid = 0;
      chk("single_lat", en0, 0);
      cyc();
      chk("single_en", {en0, en1}, 2'b10);
      chk("single_op", op0, 5);
      chk("single_dx", datax0, 7);
      cyc();
      chk("single_pulse", en0, 0);

      // Dual issue, then slot 0 busy
      slot_busy0 = 1; slot_busy1 = 1;
      put(10, 0, 0, 0, 1, 1, 1); cyc();
      put(11, 0, 0, 0, 2, 2, 2); cyc();
      in_valid = 0; slot_busy0 = 0; slot_busy1 = 0;
      cyc();
      chk("dual_en", {en0, en1}, 2'b11);
      chk("dual_ops", {op0, op1}, {6'd10, 6'd11});
      slot_busy0 = 1; slot_busy1 = 1;
      put(12, 0, 0, 0, 3, 3, 3); cyc();
      put(13, 0, 0, 0, 4, 4, 4); cyc();
      in_valid = 0; slot_busy1 = 0;
      cyc();
      chk("b0_first", {en0, en1, op1}, {2'b01, 6'd12});
      cyc();
      chk("b0_gap", {en0, en1}, 2'b00);
      cyc();
      chk("b0_second", {en0, en1, op1}, {2'b01, 6'd13});

      // Full queue
      slot_busy0 = 1; slot_busy1 = 1;
      for (int k = 0; k < 4; k++) begin
         put(6'(20 + k), 0, 0, 0, 32'(k), 0, 0);
         cyc();
      end
      put(24, 0, 0, 0, 0, 0, 0);
      chk("full_ready", in_ready, 0);
      cyc();
      in_valid = 0; slot_busy0 = 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("full_issue", {en0, op0}, {1'b1, 6'(20 + k)});
         if (k == 0) chk("full_ready_back", in_ready, 1);
         cyc();
         chk("full_gap", en0, 0);
      end
      cyc();
      chk("full_no5th", {en0, en1}, 2'b00);

      // Wakeup: queued, incoming, and at dispatch
      slot_busy0 = 1;
      put(30, 3, 4, 6, 1, 2, 7); cyc();
      put(31, 7, 0, 0, 0, 32'h22, 2);
      res_valid0 = 1; res_tag0 = 3; res_data0 = 32'hDEAD;
      res_valid1 = 1; res_tag1 = 7; res_data1 = 32'h1234;
      cyc();
      in_valid = 0;
      res_tag0 = 4; res_data0 = 32'hBEEF; res_tag1 = 4; res_data1 = 32'hCAFE;
      cyc();
      res_valid1 = 0; res_tag0 = 6; res_data0 = 32'h55;
      slot_busy0 = 0; slot_busy1 = 0;
      cyc();
      res_valid0 = 0;
      chk("wk_en", {en0, en1, op0, op1}, {2'b11, 6'd30, 6'd31});
      chk("wk_x0", {tagx0, datax0}, {5'd0, 32'hDEAD});
      chk("wk_y0", {tagy0, datay0}, {5'd0, 32'hBEEF});
      chk("wk_w0", tagw0, 0);
      chk("wk_x1", {tagx1, datax1}, {5'd0, 32'h1234});

      // Flush overrides enqueue
      slot_busy0 = 1; slot_busy1 = 1;
      for (int k = 0; k < 3; k++) begin
         put(6'(40 + k), 0, 0, 0, 0, 0, 0);
         cyc();
      end
      put(43, 0, 0, 0, 0, 0, 0); flush = 1;
      cyc();
      flush = 0; in_valid = 0; slot_busy0 = 0; slot_busy1 = 0;
      cyc();
      chk("flush_en_a", {en0, en1}, 2'b00);
      cyc();
      chk("flush_en_b", {en0, en1}, 2'b00);
      chk("flush_ready", in_ready, 1);

      // rdy low freezes
      slot_busy0 = 1; slot_busy1 = 1;
      put(50, 0, 0, 0, 0, 0, 0); cyc();
      put(51, 0, 0, 0, 0, 0, 0); cyc();
      in_valid = 0; rdy = 0; slot_busy0 = 0; slot_busy1 = 0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("rdy_low_en", {en0, en1}, 2'b00);
      end
      rdy = 1;
      cyc();
      chk("rdy_resume", {en0, en1, op0, op1}, {2'b11, 6'd50, 6'd51});

      // Reset mid-run, then pointer wrap
      slot_busy0 = 1; slot_busy1 = 1;
      put(60, 0, 0, 0, 0, 0, 0); cyc();
      put(61, 0, 0, 0, 0, 0, 0); cyc();
      in_valid = 0; rst = 1;
      #1;
      chk("rst_mid_ready", in_ready, 0);
      cyc();
      chk("rst_mid_en", {en0, en1, op0, op1}, {2'b00, 6'd0, 6'd0});
      rst = 0; slot_busy0 = 0; slot_busy1 = 0;
      for (int k = 0; k < 9; k++) begin
         put(6'(70 + k), 0, 0, 0, 32'(k), 0, 5'(k));
         cyc();
         if (k == 0) chk("rst_no_pulse", {en0, en1}, 2'b00);
         if (en0) got.push_back(op0);
         if (en1) got.push_back(op1);
      end
      in_valid = 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (en0) got.push_back(op0);
         if (en1) got.push_back(op1);
      end
      chk("wrap_count", got.size(), 9);
      for (int k = 0; k < got.size(); k++) chk("wrap_order", got[k], 6'(70 + k));

      cyc();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
